mci_cif_arb: RTL and testbench
==============================

MCI_CIF_ARB -- requirements
Module: mci_cif_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, CIF address width, shall be passed to all three interface instances.
REQ-002 Parameter DATA_WIDTH, default 32, CIF data width (wstrb = DATA_WIDTH/8).
REQ-003 Parameter ID_WIDTH, default 8, CIF id width.
REQ-004 Parameter USER_WIDTH, default 32, CIF user width.
REQ-005 Parameter TIMEOUT_CYCLES, default 255, maximum owner-idle cycles mid-burst (1..65535).
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-high.
REQ-008 req0  cif_if.response  interface  requester 0 (higher priority on tie after reset).
REQ-009 req1  cif_if.response  interface  requester 1.
REQ-010 rsp  cif_if.request  interface  shared downstream responder.
REQ-011 grant  output  2  one-hot current owner; 2'b00 when no owner.
REQ-012 arb_timeout  output  1  single-cycle pulse on forced release.

Function
REQ-013 Beat accepted on rsp shall mean rsp.dv=1 and rsp.hold=0 in the same cycle.
REQ-014 States IDLE and OWNED; owner register (0/1) valid only in OWNED.
REQ-015 IDLE: picker selects among asserted reqN.dv; one requester -> that one; both -> requester indicated by rr pointer; none -> rsp.dv=0, rsp.req_data=0.
REQ-016 Selection in IDLE shall forward the selected dv/req_data to rsp combinationally (zero-cycle latency).
REQ-017 IDLE->OWNED when selected beat is not accepted (hold=1) or is accepted with req_data.last=0; owner := selected.
REQ-018 OWNED: only owner's dv/req_data forwarded; no re-arbitration.
REQ-019 OWNED->IDLE when owner beat accepted with last=1.
REQ-020 IDLE single-beat (last=1) accepted in same cycle shall stay IDLE, no owner registered.
REQ-021 rr pointer shall point to the non-winner after every last=1 acceptance; unchanged otherwise; reset value 0.
REQ-022 Routed requester receives rsp.hold, rsp.rdata, rsp.error unmodified.
REQ-023 Non-routed requester shall see hold=1, rdata=0, error=0.
REQ-024 Idle counter (16 bit): cleared on entering OWNED and on any cycle owner dv=1; increments each OWNED cycle owner dv=0; saturates.
REQ-025 Counter reaching TIMEOUT_CYCLES shall force OWNED->IDLE next edge, pulse arb_timeout one cycle, advance rr pointer to non-owner.
REQ-026 grant shall reflect registered owner in OWNED and combinational selection in IDLE.
REQ-027 Simultaneous last=1 acceptance and timeout: acceptance wins, no arb_timeout pulse.

Reset
REQ-028 rst=1 shall immediately force state IDLE, rr pointer 0, counter 0, arb_timeout 0, registered grant 0.
REQ-029 Reset mid-burst shall drop ownership; no beat completion shall be reported for the interrupted burst after deassertion.

Structure
REQ-030 Package mci_cif_arb_pkg shall hold state enum (IDLE, OWNED), owner typedef, counter width constant (16).
REQ-031 One sub-module mci_cif_arb_rr: 2-way round-robin picker, inputs 2 requests + pointer, output one-hot select.

Verification
REQ-032 req0 only, single beat last=1, hold=0 -> rsp.dv same cycle, grant=01, state stays IDLE, pointer->1.
REQ-033 Both dv after reset, last=1 each, hold=0 -> req0 served cycle 0, req1 cycle 1, req1 hold=1 during cycle 0.
REQ-034 req1 4-beat burst (last on beat 4), req0 dv from beat 2 -> req1 all 4 beats contiguous, req0 served after, grant=10 throughout burst.
REQ-035 req0 beat with rsp.hold=1 for 5 cycles then 0, req1 dv meanwhile -> req0 stays owner, req1 sees hold=1, rdata=0.
REQ-036 TIMEOUT_CYCLES=4, req0 last=0 beat accepted then dv=0 -> arb_timeout pulse exactly once on 5th cycle, grant=00, req1 wins next.
REQ-037 rst asserted mid req1 burst -> grant=00 and rsp.dv=0 same cycle; after release req0 wins tie.

Source files
------------

// File: rtl/mci_cif_arb_pkg.sv
// mci_cif_arb_pkg: shared types and constants for the two-requester CIF arbiter
package mci_cif_arb_pkg;
  typedef enum logic {IDLE, OWNED} state_t;
  typedef logic owner_t;
  localparam int CNT_W = 16;
  function automatic logic [1:0] onehot(owner_t o);
    return o ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/cif_if.sv
// cif_if: CIF request/response channel with a packed request payload
interface cif_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 32
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic [ID_WIDTH-1:0]     id;
    logic [USER_WIDTH-1:0]   user;
    logic                    write;
    logic                    last;
  } req_t;
  logic dv;
  logic hold;
  req_t req_data;
  logic [DATA_WIDTH-1:0] rdata;
  logic error;
  modport request (output dv, req_data, input hold, rdata, error);
  modport response (input dv, req_data, output hold, rdata, error);
endinterface

// File: rtl/mci_cif_arb_rr.sv
// mci_cif_arb_rr: 2-way round-robin picker; pointer breaks ties only
module mci_cif_arb_rr import mci_cif_arb_pkg::*; (
  input  logic [1:0] req,
  input  owner_t     ptr,
  output logic [1:0] sel
);
  assign sel = &req ? onehot(ptr) : req;
endmodule

// File: rtl/mci_cif_arb.sv
// mci_cif_arb: arbitrates two CIF requesters onto one responder, holding
// ownership for whole bursts with an owner-idle timeout.
module mci_cif_arb import mci_cif_arb_pkg::*; #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int USER_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  cif_if.response    req0,
  cif_if.response    req1,
  cif_if.request     rsp,
  output logic [1:0] grant,
  output logic       arb_timeout
);
  localparam int REQ_W = ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + ID_WIDTH + USER_WIDTH + 2;
  state_t state;
  owner_t owner, ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0] pick, sel;
  logic fwd_dv, fwd_last, acc, own_dv, to_hit;
  mci_cif_arb_rr u_rr (.req({req1.dv, req0.dv}), .ptr(ptr), .sel(pick));
  // Reset gates the routing combinationally so ownership drops in the reset cycle itself
  always_comb begin
    sel = rst ? 2'b00 : state == OWNED ? onehot(owner) : pick;
    grant = sel;
    fwd_dv = sel[0] ? req0.dv : sel[1] & req1.dv;
    fwd_last = sel[0] ? req0.req_data.last : req1.req_data.last;
    acc = fwd_dv & ~rsp.hold;
    own_dv = owner ? req1.dv : req0.dv;
    to_hit = state == OWNED && cnt >= CNT_W'(TIMEOUT_CYCLES) && !(acc && fwd_last);
    arb_timeout = to_hit;
    rsp.dv = fwd_dv;
    rsp.req_data = sel[0] ? req0.req_data : sel[1] ? req1.req_data : REQ_W'(0);
    req0.hold = sel[0] ? rsp.hold : 1'b1;
    req0.rdata = sel[0] ? rsp.rdata : DATA_WIDTH'(0);
    req0.error = sel[0] & rsp.error;
    req1.hold = sel[1] ? rsp.hold : 1'b1;
    req1.rdata = sel[1] ? rsp.rdata : DATA_WIDTH'(0);
    req1.error = sel[1] & rsp.error;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      ptr <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (acc && fwd_last) ptr <= ~sel[1];
      else if (fwd_dv) begin
        state <= OWNED;
        owner <= sel[1];
        cnt <= '0;
      end
    end else if ((acc && fwd_last) || to_hit) begin
      state <= IDLE;
      ptr <= ~owner;
    end else cnt <= own_dv ? '0 : cnt + CNT_W'(~&cnt);
endmodule

// File: tb/tb_mci_cif_arb.sv
// tb_mci_cif_arb: directed scenarios with a scoreboard of expected accepted beats
module tb_mci_cif_arb;
  logic clk = 0, rst = 1;
  logic [1:0] grant;
  logic arb_timeout;
  int checks = 0, fails = 0;
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] tag;
    logic        last;
    logic [1:0]  grant;
  } exp_t;
  exp_t q[$];
  exp_t e, g;

  cif_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .USER_WIDTH(32)) i0 ();
  cif_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .USER_WIDTH(32)) i1 ();
  cif_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8), .USER_WIDTH(32)) ir ();

  mci_cif_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req0(i0), .req1(i1), .rsp(ir),
    .grant(grant), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (ir.dv && !ir.hold) begin
      checks++;
      g = {ir.req_data.id, ir.req_data.wdata, ir.req_data.last, grant};
      if (q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got %h required none", g);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL beat_order: got %h required %h", g, e);
        end
      end
    end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push(input int id, input logic [31:0] tag, input logic last, input logic [1:0] gr);
    q.push_back({8'(id), tag, last, gr});
  endtask

  task automatic drv(input int p, input logic v, input logic [31:0] tag = 0, input logic l = 0);
    if (p == 0) begin
      i0.dv = v; i0.req_data = '0; i0.req_data.id = 8'd0;
      i0.req_data.wdata = tag; i0.req_data.last = l;
    end else begin
      i1.dv = v; i1.req_data = '0; i1.req_data.id = 8'd1;
      i1.req_data.wdata = tag; i1.req_data.last = l;
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    drv(0, 1, 32'hEE, 1); drv(1, 0);
    ir.hold = 0; ir.rdata = 0; ir.error = 0;
    smp;
    chk("rst_grant", grant, 2'b00);
    chk("rst_dv", ir.dv, 0);
    chk("rst_timeout", arb_timeout, 0);
    chk("rst_r0_hold", i0.hold, 1);
    nxt; rst = 0; drv(0, 0);
    // single beat from req0, stays IDLE
    nxt; drv(0, 1, 32'hA1, 1); push(0, 32'hA1, 1, 2'b01);
    smp; chk("a_grant", grant, 2'b01); chk("a_dv", ir.dv, 1); chk("a_r1_hold", i1.hold, 1);
    nxt; drv(0, 0);
    smp; chk("a_idle_grant", grant, 2'b00);
    nxt; drv(0, 1, 32'hA2, 1); drv(1, 1, 32'hA3, 1); push(1, 32'hA3, 1, 2'b10); push(0, 32'hA2, 1, 2'b01);
    smp; chk("a_rr_grant", grant, 2'b10); chk("a_r0_hold", i0.hold, 1);
    nxt; drv(1, 0);
    smp; chk("a_r0_grant", grant, 2'b01);
    nxt; drv(0, 0);
    nxt; rst = 1; nxt; rst = 0;
    // tie after reset
    nxt; drv(0, 1, 32'hB0, 1); drv(1, 1, 32'hB1, 1); push(0, 32'hB0, 1, 2'b01); push(1, 32'hB1, 1, 2'b10);
    smp; chk("b_grant0", grant, 2'b01); chk("b_r1_hold", i1.hold, 1);
    nxt; drv(0, 0);
    smp; chk("b_grant1", grant, 2'b10);
    nxt; drv(1, 0);
    // req1 4-beat burst, req0 arrives on beat 2
    nxt; drv(1, 1, 32'hC1, 0); push(1, 32'hC1, 0, 2'b10);
    smp; chk("c_grant1", grant, 2'b10);
    nxt; drv(1, 1, 32'hC2, 0); drv(0, 1, 32'hD0, 1); push(1, 32'hC2, 0, 2'b10);
    smp; chk("c_grant2", grant, 2'b10); chk("c_r0_hold", i0.hold, 1);
    nxt; drv(1, 1, 32'hC3, 0); push(1, 32'hC3, 0, 2'b10);
    smp; chk("c_grant3", grant, 2'b10);
    nxt; drv(1, 1, 32'hC4, 1); push(1, 32'hC4, 1, 2'b10);
    smp; chk("c_grant4", grant, 2'b10);
    nxt; drv(1, 0); push(0, 32'hD0, 1, 2'b01);
    smp; chk("c_d0_grant", grant, 2'b01);
    nxt; drv(0, 0);
    // responder stalls req0 for 5 cycles while req1 waits
    nxt; drv(0, 1, 32'hE0, 1); ir.hold = 1; ir.rdata = 32'hDEADBEEF; push(0, 32'hE0, 1, 2'b01);
    smp; chk("d_grant0", grant, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      nxt; if (k == 1) drv(1, 1, 32'hF0, 1);
      smp; chk("d_grant", grant, 2'b01); chk("d_r1_hold", i1.hold, 1);
      chk("d_r1_rdata", i1.rdata, 0); chk("d_r0_rdata", i0.rdata, 32'hDEADBEEF);
      chk("d_timeout", arb_timeout, 0);
    end
    nxt; ir.hold = 0; push(1, 32'hF0, 1, 2'b10);
    smp; chk("d_release_grant", grant, 2'b01);
    nxt; drv(0, 0);
    smp; chk("d_f0_grant", grant, 2'b10);
    nxt; drv(1, 0); ir.rdata = 0;
    // owner goes quiet mid-burst: timeout on 5th cycle
    nxt; drv(0, 1, 32'h60, 0); push(0, 32'h60, 0, 2'b01);
    smp;
    for (int k = 1; k <= 5; k++) begin
      nxt; if (k == 1) drv(0, 0);
      smp; chk("e_timeout", arb_timeout, k == 5); chk("e_grant", grant, 2'b01);
    end
    nxt;
    smp; chk("e_timeout_after", arb_timeout, 0); chk("e_grant_free", grant, 2'b00);
    nxt; drv(0, 1, 32'h10, 1); drv(1, 1, 32'h70, 1); push(1, 32'h70, 1, 2'b10); push(0, 32'h10, 1, 2'b01);
    smp; chk("e_r1_wins", grant, 2'b10);
    nxt; drv(1, 0);
    smp; chk("e_r0_after", grant, 2'b01);
    nxt; drv(0, 0);
    // last beat accepted in the timeout cycle: no pulse
    nxt; drv(0, 1, 32'h90, 0); push(0, 32'h90, 0, 2'b01);
    smp;
    for (int k = 1; k <= 4; k++) begin
      nxt; if (k == 1) drv(0, 0);
      smp; chk("g_timeout", arb_timeout, 0);
    end
    nxt; drv(0, 1, 32'h91, 1); push(0, 32'h91, 1, 2'b01);
    smp; chk("g_no_pulse", arb_timeout, 0); chk("g_grant", grant, 2'b01);
    nxt; drv(0, 0);
    smp; chk("g_idle", grant, 2'b00);
    // reset in the middle of a req1 burst
    nxt; drv(1, 1, 32'hB10, 0); push(1, 32'hB10, 0, 2'b10);
    smp;
    nxt; drv(1, 1, 32'hB11, 0); push(1, 32'hB11, 0, 2'b10);
    smp;
    nxt; drv(1, 1, 32'hB12, 0); drv(0, 1, 32'hC00, 1); rst = 1;
    smp; chk("f_rst_grant", grant, 2'b00); chk("f_rst_dv", ir.dv, 0); chk("f_rst_r1_hold", i1.hold, 1);
    nxt; rst = 0; drv(1, 1, 32'hB20, 1); push(0, 32'hC00, 1, 2'b01); push(1, 32'hB20, 1, 2'b10);
    smp; chk("f_tie_grant", grant, 2'b01);
    nxt; drv(0, 0);
    smp; chk("f_r1_grant", grant, 2'b10);
    nxt; drv(1, 0);
    smp; chk("f_idle", grant, 2'b00);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
